change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
// - Consumer end of the timekeeper timeout: on a rising edge of timeout, latches current_total
//   and returns it as change, one coin per cycle, largest denomination first (greedy).
// - Reports each dispensed value so the vending total register can subtract it.
// - Sits between the timekeeper, the total register and the coin-return outputs.
// PARAMETERS
// - TOTAL_W    32    width of totals and returned values
// - NUM_COINS  3     coin kinds, equals `kNumCoins
// - COIN_VAL0  100   value of coin index 0, the smallest coin
// - COIN_VAL1  500   value of coin index 1
// - COIN_VAL2  1000  value of coin index 2, the largest coin
// PORTS
// - clk            in   1          clock, rising edge
// - reset_n        in   1          synchronous, active-low reset
// - timeout        in   1          timekeeper request; level held while the total is non-zero
// - current_total  in   TOTAL_W    running total; sampled only at the trigger
// - return_coin    out  NUM_COINS  one-hot; one cycle per coin dispensed
// - return_value   out  TOTAL_W    value of the coin on return_coin this cycle, else 0
// - busy           out  1          high from the LATCH cycle through the DONE cycle
// - done           out  1          one-cycle pulse when dispensing ends
// - residue        out  1          held high from done until the next trigger if remainder != 0
// BEHAVIOUR
// - Reset
//   - Applied when reset_n is low at a clk edge.
//   - State=IDLE; all outputs 0; internal remaining=0; timeout_q=0.
//   - Reset mid-dispense aborts immediately; coins already pulsed are not recalled.
// - Trigger
//   - Trigger = timeout && !timeout_q; timeout_q is the timeout value registered each cycle.
//   - A level that stays high, for example with a residue, never re-triggers.
//   - Triggers outside IDLE are ignored.
// - FSM, all outputs registered
//   - IDLE: on trigger -> LATCH; remaining <= current_total; residue <= 0.
//   - LATCH: busy=1. remaining==0 -> DONE. Otherwise -> DISPENSE.
//   - DISPENSE: pick the highest index i with COIN_VALi <= remaining.
//     Assert return_coin[i]=1 and return_value=COIN_VALi for that cycle.
//     remaining <= remaining - COIN_VALi.
//     Go to DONE when the new remaining < COIN_VAL0.
//   - DONE: busy=1 and done=1 for one cycle; residue <= (remaining != 0); -> IDLE.
// - Latency
//   - Trigger seen at edge k: first coin is visible after edge k+2.
//   - A total of N coins gives done after edge k+2+N.
//   - A zero total gives done after edge k+2 with no coins.
// - Arithmetic
//   - Unsigned TOTAL_W arithmetic; the subtract never underflows because the compare is <=.
//   - return_value is zero-extended.
// - Behaviour while busy
//   - current_total and timeout changes are ignored; only the latched remaining is used.
//   - Upstream gates coin input with busy.
// - Residue
//   - A remainder not payable with COIN_VAL0 is left unpaid.
//   - residue stays high until the next trigger; the timeout level staying high does not re-trigger.
// STRUCTURE
// - Shared package vending_machine_def.v: `kNumCoins and the coin value constants.
//   The parameter defaults use these constants.
// - One sub-module, coin_select: combinational priority pick.
//   (remaining) -> (one-hot coin, coin value, none_fits).
// - The FSM, remaining register and edge detect stay in change_dispenser.
// TESTING
// - Total 1600, trigger -> coins 2,1,0 (1000,500,100) on 3 consecutive cycles; done; residue=0.
// - Total 1700 -> coins 1000,500,100,100; the sum of return_value equals 1700.
// - Total 250 -> coins 100,100; done; residue=1.
//   Hold timeout high for 10 more cycles -> no new coins.
// - Total 0 with a timeout pulse -> done 2 cycles after the trigger edge; return_coin never set.
// - Total 3000 with reset_n low after the first coin:
//   - Next cycle: all outputs 0 and the FSM in IDLE.
//   - A new trigger with total 2000 -> two coins of 1000.
// - Change current_total to 9999 while busy (total 1500) -> the output is still 1000,500.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared coin definitions and FSM state encoding for the change dispenser.
// Coin index 0 is the smallest denomination; higher indices are larger coins.
package change_dispenser_pkg;

    localparam int K_NUM_COINS  = 3;
    localparam int K_COIN_VAL0  = 100;
    localparam int K_COIN_VAL1  = 500;
    localparam int K_COIN_VAL2  = 1000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LATCH    = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy pick: the largest coin whose value fits in the remaining amount.
// none_fits flags a remainder smaller than the smallest coin.
module change_dispenser_coin_select
    import change_dispenser_pkg::*;
#(
    parameter int          TOTAL_W   = 32,
    parameter int          NUM_COINS = K_NUM_COINS,
    parameter int unsigned COIN_VAL0 = K_COIN_VAL0,
    parameter int unsigned COIN_VAL1 = K_COIN_VAL1,
    parameter int unsigned COIN_VAL2 = K_COIN_VAL2
) (
    input  logic [TOTAL_W-1:0]   remaining,
    output logic [NUM_COINS-1:0] coin,
    output logic [TOTAL_W-1:0]   coin_val,
    output logic                 none_fits
);

    localparam logic [TOTAL_W-1:0] VAL0 = TOTAL_W'(COIN_VAL0);
    localparam logic [TOTAL_W-1:0] VAL1 = TOTAL_W'(COIN_VAL1);
    localparam logic [TOTAL_W-1:0] VAL2 = TOTAL_W'(COIN_VAL2);

    always_comb begin
        coin      = '0;
        coin_val  = '0;
        none_fits = (remaining < VAL0);
        if (remaining >= VAL2) begin
            coin[2]  = 1'b1;
            coin_val = VAL2;
        end else if (remaining >= VAL1) begin
            coin[1]  = 1'b1;
            coin_val = VAL1;
        end else if (remaining >= VAL0) begin
            coin[0]  = 1'b1;
            coin_val = VAL0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// On a rising edge of timeout, latches current_total and pays it back greedily, one coin per cycle.
// Every output is registered; busy covers the latch cycle through the done pulse.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int          TOTAL_W   = 32,
    parameter int          NUM_COINS = K_NUM_COINS,
    parameter int unsigned COIN_VAL0 = K_COIN_VAL0,
    parameter int unsigned COIN_VAL1 = K_COIN_VAL1,
    parameter int unsigned COIN_VAL2 = K_COIN_VAL2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 timeout,
    input  logic [TOTAL_W-1:0]   current_total,
    output logic [NUM_COINS-1:0] return_coin,
    output logic [TOTAL_W-1:0]   return_value,
    output logic                 busy,
    output logic                 done,
    output logic                 residue
);

    state_t               state_q,     state_d;
    logic [TOTAL_W-1:0]   remaining_q, remaining_d;
    logic [NUM_COINS-1:0] coin_q,      coin_d;
    logic [TOTAL_W-1:0]   value_q,     value_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic                 residue_q,   residue_d;
    logic                 timeout_q,   timeout_d;

    logic [NUM_COINS-1:0] sel_coin;
    logic [TOTAL_W-1:0]   sel_val;
    logic                 none_fits;
    logic [TOTAL_W-1:0]   next_rem;
    logic                 trigger;

    change_dispenser_coin_select #(
        .TOTAL_W   (TOTAL_W),
        .NUM_COINS (NUM_COINS),
        .COIN_VAL0 (COIN_VAL0),
        .COIN_VAL1 (COIN_VAL1),
        .COIN_VAL2 (COIN_VAL2)
    ) u_coin_select (
        .remaining (remaining_q),
        .coin      (sel_coin),
        .coin_val  (sel_val),
        .none_fits (none_fits)
    );

    assign trigger  = timeout && !timeout_q;
    assign next_rem = remaining_q - sel_val;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = '0;
        value_d     = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        residue_d   = residue_q;
        timeout_d   = timeout;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (trigger) begin
                    state_d     = ST_LATCH;
                    remaining_d = current_total;
                    residue_d   = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            // A latched amount below the smallest coin (including zero) pays nothing.
            ST_LATCH: state_d = none_fits ? ST_DONE : ST_DISPENSE;
            ST_DISPENSE: begin
                coin_d      = sel_coin;
                value_d     = sel_val;
                remaining_d = next_rem;
                if (next_rem < TOTAL_W'(COIN_VAL0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d    = 1'b1;
                residue_d = (remaining_q != '0);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            coin_q      <= '0;
            value_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            residue_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            value_q     <= value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            residue_q   <= residue_d;
            timeout_q   <= timeout_d;
        end
    end

    assign return_coin  = coin_q;
    assign return_value = value_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign residue      = residue_q;

endmodule
